// File: rtl/world_time_conv.sv
// ---------------------------------------------------------------------------
// world_time_conv
//
// Converts the reference-zone calendar time coming from the timekeeping
// counter into the local time of a selectable zone. Zone offsets and
// three-character tags live in a small programmable table. Offsets are signed
// multiples of STEP_MIN minutes. The result is a registered snapshot for the
// LCD formatter, and a one-cycle valid strobe marks each new snapshot.
//
// Ports:
//   clk                      system clock
//   rst                      synchronous reset, active low
//   sw_in[3:0]               key code: 4'b1000 next zone, 4'b0100 previous zone
//   upd                      one-cycle recompute request (1 s tick)
//   year, month, day,
//   hour, minute, second     reference date/time, binary
//   week[2:0]                reference weekday, 0 = SUN .. 6 = SAT
//   tbl_wr                   table write strobe
//   tbl_addr[ZONE_W-1:0]     table write address
//   tbl_off[6:0]             signed offset in STEP_MIN units
//   tbl_tag[23:0]            three ASCII characters
//   zone_sel, zone_tag       current zone index and its tag
//   loc_*                    local date/time snapshot
//   busy                     conversion in progress
//   valid                    one-cycle strobe, loc_* just updated
//   err                      last conversion saw an invalid input date
//
// Optional build macro WTC_DST_EN adds the dst input and the tbl_dst table
// bit. When dst=1 and the selected entry allows it, the zone gains one hour.
// ---------------------------------------------------------------------------
module world_time_conv #(
  parameter int NUM_ZONES = 18,
  parameter int ZONE_W    = 5,
  parameter int STEP_MIN  = 15,
  parameter int YEAR_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        sw_in,
  input  logic              upd,
  input  logic [YEAR_W-1:0] year,
  input  logic [7:0]        month,
  input  logic [7:0]        day,
  input  logic [7:0]        hour,
  input  logic [7:0]        minute,
  input  logic [7:0]        second,
  input  logic [2:0]        week,
  input  logic              tbl_wr,
  input  logic [ZONE_W-1:0] tbl_addr,
  input  logic [6:0]        tbl_off,
  input  logic [23:0]       tbl_tag,
`ifdef WTC_DST_EN
  input  logic              dst,
  input  logic              tbl_dst,
`endif
  output logic [ZONE_W-1:0] zone_sel,
  output logic [23:0]       zone_tag,
  output logic [YEAR_W-1:0] loc_year,
  output logic [7:0]        loc_month,
  output logic [7:0]        loc_day,
  output logic [7:0]        loc_hour,
  output logic [7:0]        loc_minute,
  output logic [7:0]        loc_second,
  output logic [2:0]        loc_week,
  output logic              busy,
  output logic              valid,
  output logic              err
);

  localparam logic [ZONE_W-1:0] LastZone = ZONE_W'(NUM_ZONES - 1);
  localparam logic [23:0]       TagUtc   = 24'h555443;
  localparam logic [23:0]       TagBlank = 24'h202020;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DIV   = 3'd3,
    DATE  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Zone table and selection
  logic signed [6:0]  tblOff_q [NUM_ZONES];
  logic        [23:0] tblTag_q [NUM_ZONES];
  logic [ZONE_W-1:0]  zoneSel_q, zoneSel_d;
  logic [23:0]        zoneTag_q;
  logic               zoneChange;
  logic               tblWrOk;
  logic               wrHit;
  logic               dstChange;
  logic               reqAny;
  logic               pending_q, pending_d;

`ifdef WTC_DST_EN
  logic               tblDst_q [NUM_ZONES];
  logic               dstPrev_q;
`endif

  // Working registers of the conversion pipeline
  logic [YEAR_W-1:0]  wYear_q, wYear_d;
  logic [7:0]         wMonth_q, wMonth_d;
  logic [7:0]         wDay_q, wDay_d;
  logic [7:0]         wHour_q, wHour_d;
  logic [7:0]         wSec_q, wSec_d;
  logic [2:0]         wWeek_q, wWeek_d;
  logic signed [12:0] wT_q, wT_d;
  logic               carry_q, carry_d;
  logic               borrow_q, borrow_d;
  logic               wErr_q, wErr_d;

  logic signed [11:0] offMin;
  int                 tCalc;
  logic               dateOk;

  // Published snapshot
  logic [YEAR_W-1:0]  locYear_q;
  logic [7:0]         locMonth_q, locDay_q, locHour_q, locMinute_q, locSec_q;
  logic [2:0]         locWeek_q;
  logic               valid_q, err_q;

  // Days in a month under the full Gregorian leap rule. The year is taken
  // modulo 2^YEAR_W, the same width the year arithmetic wraps at.
  function automatic logic [7:0] maxDate(input logic [7:0] m, input logic [YEAR_W-1:0] y);
    logic [31:0] yy;
    logic        leap;
    logic [7:0]  r;
    yy   = 32'(y);
    leap = ((yy % 32'd4) == 32'd0) &&
           (((yy % 32'd100) != 32'd0) || ((yy % 32'd400) == 32'd0));
    case (m)
      8'd2:                      r = leap ? 8'd29 : 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11:   r = 8'd30;
      default:                   r = 8'd31;
    endcase
    return r;
  endfunction

  // Key decoding: the debouncer delivers one-cycle codes. Both directions
  // wrap around the populated part of the table, and any move asks for a
  // fresh conversion.
  always_comb begin
    zoneSel_d  = zoneSel_q;
    zoneChange = 1'b0;
    if (sw_in == 4'b1000) begin
      zoneChange = 1'b1;
      zoneSel_d  = (zoneSel_q == LastZone) ? '0 : zoneSel_q + ZONE_W'(1);
    end else if (sw_in == 4'b0100) begin
      zoneChange = 1'b1;
      zoneSel_d  = (zoneSel_q == '0) ? LastZone : zoneSel_q - ZONE_W'(1);
    end
  end

  // Table writes outside the populated range are dropped. Rewriting the
  // zone on display must refresh the shown time, so it counts as a request.
  assign tblWrOk = tbl_wr && (int'(tbl_addr) < NUM_ZONES);
  assign wrHit   = tblWrOk && (tbl_addr == zoneSel_q);

`ifdef WTC_DST_EN
  assign dstChange = dst ^ dstPrev_q;
`else
  assign dstChange = 1'b0;
`endif

  assign reqAny = upd | zoneChange | wrHit | dstChange;

  assign dateOk = (month >= 8'd1) && (month <= 8'd12) &&
                  (day >= 8'd1) && (day <= maxDate(month, year));

  // Table storage, zone index and the registered tag read. The tag follows
  // table[zone_sel] one cycle later, so both a select and a write to the
  // current entry show up on the next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ZONES; i++) begin
        tblOff_q[i] <= '0;
        tblTag_q[i] <= (i == 0) ? TagUtc : TagBlank;
`ifdef WTC_DST_EN
        tblDst_q[i] <= 1'b0;
`endif
      end
      zoneSel_q <= '0;
      zoneTag_q <= TagUtc;
`ifdef WTC_DST_EN
      dstPrev_q <= 1'b0;
`endif
    end else begin
      if (tblWrOk) begin
        tblOff_q[tbl_addr] <= tbl_off;
        tblTag_q[tbl_addr] <= tbl_tag;
`ifdef WTC_DST_EN
        tblDst_q[tbl_addr] <= tbl_dst;
`endif
      end
      zoneSel_q <= zoneSel_d;
      zoneTag_q <= tblTag_q[zoneSel_q];
`ifdef WTC_DST_EN
      dstPrev_q <= dst;
`endif
    end
  end

  // Conversion FSM, next-state and datapath. Time of day is handled as
  // minutes since midnight in t: one 24-hour correction in SHIFT covers the
  // whole offset range, DIV peels off hours by repeated subtraction, and DATE
  // applies the resulting day carry/borrow to the calendar. Requests that
  // arrive while a conversion runs collapse into one pending restart.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    wYear_d   = wYear_q;
    wMonth_d  = wMonth_q;
    wDay_d    = wDay_q;
    wHour_d   = wHour_q;
    wSec_d    = wSec_q;
    wWeek_d   = wWeek_q;
    wT_d      = wT_q;
    carry_d   = carry_q;
    borrow_d  = borrow_q;
    wErr_d    = wErr_q;
    offMin    = '0;
    tCalc     = 0;

    if ((state_q != IDLE) && reqAny) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (reqAny || pending_q) begin
          state_d   = LOAD;
          pending_d = 1'b0;
        end
      end

      LOAD: begin
        wYear_d  = year;
        wMonth_d = month;
        wDay_d   = day;
        wSec_d   = second;
        wWeek_d  = week;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        offMin   = 12'(int'(tblOff_q[zoneSel_q]) * STEP_MIN);
`ifdef WTC_DST_EN
        if (dst && tblDst_q[zoneSel_q]) begin
          offMin = offMin + 12'sd60;
        end
`endif
        tCalc = int'(hour) * 60 + int'(minute) + int'(offMin);
        if (dateOk) begin
          wErr_d  = 1'b0;
          wHour_d = 8'd0;
          wT_d    = 13'(tCalc);
          state_d = SHIFT;
        end else begin
          // An invalid date is passed through untouched and flagged.
          wErr_d  = 1'b1;
          wHour_d = hour;
          wT_d    = 13'(minute);
          state_d = DONE;
        end
      end

      SHIFT: begin
        if (wT_q < 13'sd0) begin
          wT_d     = wT_q + 13'sd1440;
          borrow_d = 1'b1;
          wWeek_d  = (wWeek_q == 3'd0) ? 3'd6 : wWeek_q - 3'd1;
        end else if (wT_q >= 13'sd1440) begin
          wT_d    = wT_q - 13'sd1440;
          carry_d = 1'b1;
          wWeek_d = (wWeek_q >= 3'd6) ? 3'd0 : wWeek_q + 3'd1;
        end
        state_d = DIV;
      end

      DIV: begin
        if (wT_q >= 13'sd60) begin
          wT_d    = wT_q - 13'sd60;
          wHour_d = wHour_q + 8'd1;
        end else begin
          state_d = DATE;
        end
      end

      DATE: begin
        if (carry_q) begin
          if (wDay_q >= maxDate(wMonth_q, wYear_q)) begin
            wDay_d = 8'd1;
            if (wMonth_q == 8'd12) begin
              wMonth_d = 8'd1;
              wYear_d  = wYear_q + YEAR_W'(1);
            end else begin
              wMonth_d = wMonth_q + 8'd1;
            end
          end else begin
            wDay_d = wDay_q + 8'd1;
          end
        end else if (borrow_q) begin
          if (wDay_q == 8'd1) begin
            if (wMonth_q == 8'd1) begin
              wMonth_d = 8'd12;
              wDay_d   = 8'd31;
              wYear_d  = wYear_q - YEAR_W'(1);
            end else begin
              wMonth_d = wMonth_q - 8'd1;
              wDay_d   = maxDate(wMonth_q - 8'd1, wYear_q);
            end
          end else begin
            wDay_d = wDay_q - 8'd1;
          end
        end
        state_d = DONE;
      end

      DONE: begin
        if (pending_q || reqAny) begin
          state_d   = LOAD;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  // FSM state and working registers. Reset drops any conversion in flight
  // together with its pending restart.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      wYear_q   <= '0;
      wMonth_q  <= '0;
      wDay_q    <= '0;
      wHour_q   <= '0;
      wSec_q    <= '0;
      wWeek_q   <= '0;
      wT_q      <= '0;
      carry_q   <= 1'b0;
      borrow_q  <= 1'b0;
      wErr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wYear_q   <= wYear_d;
      wMonth_q  <= wMonth_d;
      wDay_q    <= wDay_d;
      wHour_q   <= wHour_d;
      wSec_q    <= wSec_d;
      wWeek_q   <= wWeek_d;
      wT_q      <= wT_d;
      carry_q   <= carry_d;
      borrow_q  <= borrow_d;
      wErr_q    <= wErr_d;
    end
  end

  // Published snapshot: captured as the FSM leaves DONE, so valid rises in
  // the same cycle the new values appear and the values hold until the next
  // strobe. err only changes when a conversion completes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      locYear_q   <= YEAR_W'(2000);
      locMonth_q  <= 8'd1;
      locDay_q    <= 8'd1;
      locHour_q   <= 8'd0;
      locMinute_q <= 8'd0;
      locSec_q    <= 8'd0;
      locWeek_q   <= 3'd6;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      valid_q <= (state_q == DONE);
      if (state_q == DONE) begin
        locYear_q   <= wYear_q;
        locMonth_q  <= wMonth_q;
        locDay_q    <= wDay_q;
        locHour_q   <= wHour_q;
        locMinute_q <= wT_q[7:0];
        locSec_q    <= wSec_q;
        locWeek_q   <= wWeek_q;
        err_q       <= wErr_q;
      end
    end
  end

  assign zone_sel   = zoneSel_q;
  assign zone_tag   = zoneTag_q;
  assign loc_year   = locYear_q;
  assign loc_month  = locMonth_q;
  assign loc_day    = locDay_q;
  assign loc_hour   = locHour_q;
  assign loc_minute = locMinute_q;
  assign loc_second = locSec_q;
  assign loc_week   = locWeek_q;
  assign busy       = (state_q == LOAD) || (state_q == SHIFT) ||
                      (state_q == DIV)  || (state_q == DATE);
  assign valid      = valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_world_time_conv.sv
// ---------------------------------------------------------------------------
// tb_world_time_conv
//
// Directed bench for world_time_conv with default parameters. One linear
// initial block drives reset, table writes, zone keys and conversion
// requests. Expected values are hand-computed constants. The dst steps are
// compiled in only when WTC_DST_EN is defined.
// ---------------------------------------------------------------------------
module tb_world_time_conv;

  logic        clk;
  logic        rst;
  logic [3:0]  sw_in;
  logic        upd;
  logic [11:0] year;
  logic [7:0]  month, day, hour, minute, second;
  logic [2:0]  week;
  logic        tbl_wr;
  logic [4:0]  tbl_addr;
  logic [6:0]  tbl_off;
  logic [23:0] tbl_tag;
`ifdef WTC_DST_EN
  logic        dst;
  logic        tbl_dst;
`endif
  logic [4:0]  zone_sel;
  logic [23:0] zone_tag;
  logic [11:0] loc_year;
  logic [7:0]  loc_month, loc_day, loc_hour, loc_minute, loc_second;
  logic [2:0]  loc_week;
  logic        busy, valid, err;

  int checks;
  int errors;
  int validCount;
  int lat;

  world_time_conv dut (
    .clk        (clk),
    .rst        (rst),
    .sw_in      (sw_in),
    .upd        (upd),
    .year       (year),
    .month      (month),
    .day        (day),
    .hour       (hour),
    .minute     (minute),
    .second     (second),
    .week       (week),
    .tbl_wr     (tbl_wr),
    .tbl_addr   (tbl_addr),
    .tbl_off    (tbl_off),
    .tbl_tag    (tbl_tag),
`ifdef WTC_DST_EN
    .dst        (dst),
    .tbl_dst    (tbl_dst),
`endif
    .zone_sel   (zone_sel),
    .zone_tag   (zone_tag),
    .loc_year   (loc_year),
    .loc_month  (loc_month),
    .loc_day    (loc_day),
    .loc_hour   (loc_hour),
    .loc_minute (loc_minute),
    .loc_second (loc_second),
    .loc_week   (loc_week),
    .busy       (busy),
    .valid      (valid),
    .err        (err)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison: counts it and reports a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives the reference date/time inputs
  task automatic applyStimulus(input int y, input int mo, input int d, input int h,
                               input int mi, input int s, input int w);
    year   = 12'(y);
    month  = 8'(mo);
    day    = 8'(d);
    hour   = 8'(h);
    minute = 8'(mi);
    second = 8'(s);
    week   = 3'(w);
  endtask

  task automatic pulseUpd();
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  task automatic pulseSw(input logic [3:0] code);
    sw_in = code;
    tick();
    sw_in = 4'b0000;
  endtask

  task automatic writeEntry(input int addr, input int off, input logic [23:0] tag, input logic dstOk);
    tbl_wr   = 1'b1;
    tbl_addr = 5'(addr);
    tbl_off  = 7'(off);
    tbl_tag  = tag;
`ifdef WTC_DST_EN
    tbl_dst  = dstOk;
`endif
    tick();
    tbl_wr   = 1'b0;
  endtask

  // Waits (bounded) for the valid strobe; lat is 0 if it never came
  task automatic waitValid(output int latOut);
    latOut = 0;
    for (int i = 1; i <= 40; i++) begin
      if (latOut == 0) begin
        tick();
        if (valid) latOut = i;
      end
    end
    checkOutput("latency_le_29", 32'((latOut > 0) && (latOut <= 29)), 32'd1);
  endtask

  task automatic countValid(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (valid) validCount++;
    end
  endtask

  task automatic checkLoc(input int y, input int mo, input int d, input int h,
                          input int mi, input int s, input int w);
    checkOutput("loc_year",   32'(loc_year),   32'(y));
    checkOutput("loc_month",  32'(loc_month),  32'(mo));
    checkOutput("loc_day",    32'(loc_day),    32'(d));
    checkOutput("loc_hour",   32'(loc_hour),   32'(h));
    checkOutput("loc_minute", 32'(loc_minute), 32'(mi));
    checkOutput("loc_second", 32'(loc_second), 32'(s));
    checkOutput("loc_week",   32'(loc_week),   32'(w));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    validCount = 0;
    lat = 0;
    rst = 1'b0;
    sw_in = 4'b0000;
    upd = 1'b0;
    tbl_wr = 1'b0;
    tbl_addr = '0;
    tbl_off = '0;
    tbl_tag = '0;
`ifdef WTC_DST_EN
    dst = 1'b0;
    tbl_dst = 1'b0;
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Reset state
    tick();
    tick();
    checkOutput("rst_zone_sel", 32'(zone_sel), 32'd0);
    checkOutput("rst_zone_tag", 32'(zone_tag), 32'h555443);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkLoc(2000, 1, 1, 0, 0, 0, 6);
    rst = 1'b1;
    tick();

    // Zone 0 (UTC) passes the time straight through
    applyStimulus(2024, 2, 28, 23, 50, 10, 3);
    pulseUpd();
    waitValid(lat);
    checkLoc(2024, 2, 28, 23, 50, 10, 3);
    checkOutput("utc_tag", 32'(zone_tag), 32'h555443);
    checkOutput("utc_err", 32'(err), 32'd0);

    // +9h zone: carry into 29 Feb of a leap year
    writeEntry(5, 36, "SEL", 1'b0);
    for (int i = 0; i < 5; i++) pulseSw(4'b1000);
    checkOutput("sel_zone5", 32'(zone_sel), 32'd5);
    repeat (70) tick();
    checkOutput("sel_tag", 32'(zone_tag), 32'h53454C);
    pulseUpd();
    waitValid(lat);
    checkLoc(2024, 2, 29, 8, 50, 10, 4);

    // Same in 2100, which is not a leap year
    applyStimulus(2100, 2, 28, 23, 50, 10, 3);
    pulseUpd();
    waitValid(lat);
    checkLoc(2100, 3, 1, 8, 50, 10, 4);

    // -5h zone: borrow across New Year
    writeEntry(2, -20, "NYC", 1'b0);
    for (int i = 0; i < 3; i++) pulseSw(4'b0100);
    checkOutput("nyc_zone2", 32'(zone_sel), 32'd2);
    repeat (70) tick();
    checkOutput("nyc_tag", 32'(zone_tag), 32'h4E5943);
    applyStimulus(2025, 1, 1, 2, 30, 0, 3);
    pulseUpd();
    waitValid(lat);
    checkLoc(2024, 12, 31, 21, 30, 0, 2);

    // Rewriting the displayed zone triggers a conversion without upd
    writeEntry(2, 0, "NYC", 1'b0);
    waitValid(lat);
    checkLoc(2025, 1, 1, 2, 30, 0, 3);

    // Wrap 0 -> NUM_ZONES-1 on the previous-zone key
    pulseSw(4'b0100);
    pulseSw(4'b0100);
    checkOutput("wrap_zone0", 32'(zone_sel), 32'd0);
    pulseSw(4'b0100);
    checkOutput("wrap_zone17", 32'(zone_sel), 32'd17);
    repeat (70) tick();
    checkOutput("blank_tag", 32'(zone_tag), 32'h202020);

    // upd held during busy plus a second upd gives exactly two strobes
    validCount = 0;
    pulseUpd();
    countValid(3);
    upd = 1'b1;
    countValid(3);
    upd = 1'b0;
    countValid(84);
    checkOutput("two_strobes", 32'(validCount), 32'd2);

    // Invalid month: flagged and passed through unconverted
    applyStimulus(2025, 13, 5, 10, 20, 30, 1);
    pulseUpd();
    waitValid(lat);
    checkOutput("bad_err", 32'(err), 32'd1);
    checkLoc(2025, 13, 5, 10, 20, 30, 1);

    // A valid date clears err again
    applyStimulus(2023, 6, 15, 12, 0, 0, 4);
    pulseUpd();
    waitValid(lat);
    checkOutput("good_err", 32'(err), 32'd0);
    checkLoc(2023, 6, 15, 12, 0, 0, 4);

    // Day 31 in a 30-day month is also invalid
    applyStimulus(2023, 4, 31, 1, 2, 3, 5);
    pulseUpd();
    waitValid(lat);
    checkOutput("bad_day_err", 32'(err), 32'd1);

    // Reset while in DIV: everything back to reset values, no strobe later
    applyStimulus(2024, 5, 10, 23, 59, 0, 5);
    pulseUpd();
    repeat (4) tick();
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    checkOutput("mid_rst_zone_sel", 32'(zone_sel), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_valid", 32'(valid), 32'd0);
    checkOutput("mid_rst_err", 32'(err), 32'd0);
    checkLoc(2000, 1, 1, 0, 0, 0, 6);
    rst = 1'b1;
    validCount = 0;
    countValid(40);
    checkOutput("no_strobe_after_rst", 32'(validCount), 32'd0);

`ifdef WTC_DST_EN
    // Summer time on an entry that allows it: +1h across midnight
    writeEntry(0, 0, "LON", 1'b1);
    dst = 1'b1;
    repeat (70) tick();
    applyStimulus(2024, 3, 10, 23, 30, 0, 0);
    pulseUpd();
    waitValid(lat);
    checkLoc(2024, 3, 11, 0, 30, 0, 1);

    // Same entry with dst_ok cleared: offset used as stored
    writeEntry(0, 0, "LON", 1'b0);
    waitValid(lat);
    checkLoc(2024, 3, 10, 23, 30, 0, 0);
    dst = 1'b0;
    repeat (40) tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/world_time_conv.md
Name: world_time_conv

Overview:
- Parametrised successor to the watch GMT-offset display path.
- Converts the reference-zone calendar time (year/month/day/hour/minute/second/week) into the local time of a selectable zone. Zones come from a programmable table with signed quarter-hour offsets.
- Carries and borrows fully through minute, hour, day, month, year and weekday.
- Sits between the timekeeping counter and the LCD character formatter. Publishes a registered local-time snapshot with a valid strobe.

Parameters:
- NUM_ZONES, 18, number of table entries (2..32).
- ZONE_W, 5, zone index width; must satisfy 2^ZONE_W >= NUM_ZONES.
- STEP_MIN, 15, offset granularity in minutes.
- YEAR_W, 12, year field width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- sw_in  in  4  key code; 4'b1000 = next zone, 4'b0100 = previous zone, others ignored
- upd  in  1  one-cycle request to recompute (tied to the 1 s tick)
- year  in  YEAR_W  reference year
- month, day, hour, minute, second  in  8 each  reference date/time, binary
- week  in  3  reference weekday, 0 = SUN .. 6 = SAT
- tbl_wr  in  1  table write strobe
- tbl_addr  in  ZONE_W  table write address
- tbl_off  in  7  signed offset in STEP_MIN units (-48..+56)
- tbl_tag  in  24  three ASCII characters
- zone_sel  out  ZONE_W  current zone index
- zone_tag  out  24  tag of the current zone
- loc_year  out  YEAR_W  local year
- loc_month, loc_day, loc_hour, loc_minute, loc_second  out  8 each  local date/time
- loc_week  out  3  local weekday
- busy  out  1  computation in progress
- valid  out  1  one-cycle strobe: loc_* updated
- err  out  1  input date invalid

Behaviour:
- Reset: applied when rst=0 at a clk edge.
  - zone_sel=0; busy=0; valid=0; err=0.
  - loc_* = 2000/01/01 00:00:00; loc_week=6.
  - Table: entry 0 = offset 0, tag "UTC"; all other entries = offset 0, tag "   " (8'h20 x3).
  - Any computation in flight is abandoned.
- Zone select:
  - sw_in==4'b1000: zone_sel+1, wrapping NUM_ZONES-1 -> 0.
  - sw_in==4'b0100: zone_sel-1, wrapping 0 -> NUM_ZONES-1.
  - sw_in is a one-cycle pulse from the debouncer. Every zone change raises an internal recompute request.
- Table write:
  - Occurs on tbl_wr=1 at the clock edge.
  - Addresses >= NUM_ZONES are ignored.
  - Writing the current zone raises a recompute request.
  - zone_tag is a registered read of table[zone_sel], updated on the cycle after a select or write.
- Request handling:
  - upd or an internal request while IDLE starts computation on the next cycle.
  - A request while busy sets a single pending flag. On DONE, the FSM restarts immediately; further requests merge into that flag.
- FSM states: IDLE -> LOAD -> SHIFT -> DIV -> DATE -> DONE -> IDLE.
  - LOAD: latch all inputs and table[zone_sel]. off_min = off*STEP_MIN (signed 12-bit). t = hour*60 + minute + off_min (signed 13-bit). busy=1.
  - Input check (in LOAD): month outside 1..12, or day outside 1..max_date(month,year). Then err=1, loc_* = inputs unconverted, jump straight to DONE. err stays 1 until the next valid conversion.
  - SHIFT (one cycle):
    - t<0: t+=1440, day borrow (-1).
    - t>=1440: t-=1440, day carry (+1).
    - Otherwise: no change.
    - loc_week is adjusted by the same carry/borrow, modulo 7.
  - DIV: subtract 60 per cycle until t<60, counting hours. Worst case 24 cycles. Then hour = count, minute = t.
  - DATE (one cycle):
    - Carry past max_date: day=1, month+1; December -> January, year+1.
    - Borrow to day 0: move to the previous month, day = max_date of that month; January -> December, year-1.
  - DONE: register loc_*, pulse valid for one cycle, busy=0. loc_second = latched second, unchanged.
- Latency: upd to valid is at most 29 cycles. loc_* hold their values between strobes.
- max_date: 31/30 by month. February = 28 + leap.
  - Leap is full Gregorian: divisible by 4, and not by 100 unless by 400.
- Year arithmetic wraps modulo 2^YEAR_W. No saturation.

Optional Feature:
- Macro WTC_DST_EN.
- When defined: adds input port dst (1 bit) and a per-entry dst_ok bit, written with the tbl_dst input alongside tbl_off. When dst=1 and the entry's dst_ok=1, off_min gains +60 before SHIFT. A change on dst raises a recompute request.
- When undefined: no dst ports and no extra table bit; offsets are used exactly as stored.

Test Plan:
- Reset, then upd with 2024/02/28 23:50:10 week=3 on zone 0 -> valid within 29 cycles; loc = 2024/02/28 23:50:10, week 3, zone_tag "UTC".
- Write entry 5 = +36 (9h) "SEL"; select it with five 1000 pulses; upd with 2024/02/28 23:50 -> loc = 2024/02/29 08:50, week 4. Repeat with year 2100 -> loc = 2100/03/01 08:50.
- Write entry 2 = -20 (-5h) "NYC"; upd with 2025/01/01 02:30 week=3 -> loc = 2024/12/31 21:30, week 2.
- From zone 0, one 0100 pulse -> zone_sel = NUM_ZONES-1. An upd held during busy, plus a second upd -> exactly two valid strobes.
- Input month=13 -> err=1, loc_* equal inputs. A following valid date -> err=0. rst=0 mid-DIV -> all outputs at reset values on the next cycle, and no valid pulse.
- With WTC_DST_EN, entry "LON" offset 0 with dst_ok=1, dst=1, 23:30 -> loc 00:30 next day. Same case with dst_ok=0 -> 23:30.
